equality_run_detector: RTL and testbench

- Stream stage directly downstream of the 5-bit equality comparator.
- Accepts a stream of samples over a valid/ready handshake and compares each against a loaded key.
- Emits a registered per-sample equal flag and counts consecutive matches.
- Declares lock once the run of matches reaches a threshold; used to detect a stable repeated symbol on a bus.

---
 rtl/equality_run_detector.sv | 129 ++++++++++++
 tb/tb_equality_run_detector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/equality_run_detector.sv
// Purpose: compares each accepted sample against a loaded key, reports a per-sample equal flag, tracks runs and declares lock.
// Latency: 1 cycle from accept to out_valid/out_equal; counters and locked update on the same edge.
// Backpressure: single-entry output register; in_ready drops while a result is held and out_ready is low.
module equality_run_detector #(
   parameter int W         = 5,
   parameter int THRESHOLD = 3,
   parameter int CW        = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_load,
   input  logic [W-1:0]  key_in,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic          out_equal,
   input  logic          out_ready,
   output logic [CW-1:0] run_count,
   output logic [CW-1:0] match_total,
   output logic          locked
);

   // State encoding kept as plain constants for compatibility with older tooling.
   localparam logic [1:0] ST_NOKEY  = 2'd0;
   localparam logic [1:0] ST_HUNT   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] THR     = CW'(THRESHOLD);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [W-1:0]  key;
   logic          accept;
   logic          eq;
   logic          out_valid_nxt;
   logic [CW-1:0] run_inc;
   logic [CW-1:0] total_inc;
   logic [CW-1:0] run_count_nxt;
   logic [CW-1:0] match_total_nxt;
   logic          locked_nxt;

   // The output slot can take a new sample when empty or when it drains this cycle.
   assign in_ready = (state != ST_NOKEY) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Comparison uses the key already in the register, so a same-cycle load never affects it.
   assign eq = (in_data == key);

   // Saturating increments; both counters stick at all-ones rather than wrapping.
   assign run_inc   = (run_count   == CNT_MAX) ? run_count   : run_count   + 1'b1;
   assign total_inc = (match_total == CNT_MAX) ? match_total : match_total + 1'b1;

   // Output occupancy: a new accept always fills the slot; otherwise it empties only when consumed.
   always_comb begin
      out_valid_nxt = out_valid;
      if (accept) begin
         out_valid_nxt = 1'b1;
      end else if (out_ready) begin
         out_valid_nxt = 1'b0;
      end
   end

   // Run tracking and state: key_load wins over any same-cycle accept, which then only feeds the output.
   always_comb begin
      state_nxt       = state;
      run_count_nxt   = run_count;
      match_total_nxt = match_total;
      locked_nxt      = locked;
      if (key_load) begin
         state_nxt       = ST_HUNT;
         run_count_nxt   = '0;
         match_total_nxt = '0;
         locked_nxt      = 1'b0;
      end else if (accept) begin
         if (eq) begin
            run_count_nxt   = run_inc;
            match_total_nxt = total_inc;
            if (run_inc >= THR) begin
               state_nxt  = ST_LOCKED;
               locked_nxt = 1'b1;
            end
         end else begin
            run_count_nxt = '0;
            state_nxt     = ST_HUNT;
            locked_nxt    = 1'b0;
         end
      end
   end

   // Key register: reset to zero, reloaded whenever key_load is asserted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key <= '0;
      end else if (key_load) begin
         key <= key_in;
      end
   end

   // Output register: out_equal only changes on accept, so it stays stable while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_equal <= 1'b0;
      end else begin
         out_valid <= out_valid_nxt;
         if (accept) begin
            out_equal <= eq;
         end
      end
   end

   // State, counters and lock flag registered together so locked aligns with run_count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_NOKEY;
         run_count   <= '0;
         match_total <= '0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nxt;
         run_count   <= run_count_nxt;
         match_total <= match_total_nxt;
         locked      <= locked_nxt;
      end
   end

endmodule

// File: tb/tb_equality_run_detector.sv
// Purpose: directed self-checking bench for equality_run_detector.
// Latency: results checked 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low with a result pending.
module tb_equality_run_detector;

   logic       clk;
   logic       rst_n;
   logic       key_load;
   logic [4:0] key_in;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic       out_equal;
   logic       out_ready;
   logic [3:0] run_count;
   logic [3:0] match_total;
   logic       locked;

   int checks = 0;
   int errors = 0;

   equality_run_detector #(.W(5), .THRESHOLD(3), .CW(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_load    (key_load),
      .key_in      (key_in),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_equal   (out_equal),
      .out_ready   (out_ready),
      .run_count   (run_count),
      .match_total (match_total),
      .locked      (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check all registered outputs at once.
   task automatic chk_out(input string tag, input int v, input int e, input int rc,
                          input int mt, input int lk);
      chk({tag, ".out_valid"},   int'(out_valid),   v);
      chk({tag, ".out_equal"},   int'(out_equal),   e);
      chk({tag, ".run_count"},   int'(run_count),   rc);
      chk({tag, ".match_total"}, int'(match_total), mt);
      chk({tag, ".locked"},      int'(locked),      lk);
   endtask

   initial begin
      rst_n     = 1'b0;
      key_load  = 1'b0;
      key_in    = 5'd0;
      in_valid  = 1'b0;
      in_data   = 5'd0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset.in_ready", int'(in_ready), 0);

      // No key loaded: samples are refused.
      in_valid = 1'b1;
      in_data  = 5'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("nokey.in_ready", int'(in_ready), 0);
         chk_out("nokey", 0, 0, 0, 0, 0);
      end

      // Load key 7.
      in_valid = 1'b0;
      key_load = 1'b1;
      key_in   = 5'd7;
      tick();
      key_load = 1'b0;
      chk("hunt.in_ready", int'(in_ready), 1);

      // Three matches reach the threshold.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 5'd7;
      tick();
      chk_out("match1", 1, 1, 1, 1, 0);
      tick();
      chk_out("match2", 1, 1, 2, 2, 0);
      tick();
      chk_out("match3", 1, 1, 3, 3, 1);

      // Mismatch while locked drops back to hunting.
      in_data = 5'd6;
      tick();
      chk_out("miss", 1, 0, 0, 3, 0);

      // Backpressure with a held match.
      in_data = 5'd7;
      tick();
      chk_out("bp_accept", 1, 1, 1, 4, 0);
      out_ready = 1'b0;
      in_data   = 5'd2;
      #1;
      chk("bp.in_ready_low", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp.in_ready", int'(in_ready), 0);
         chk_out("bp_hold", 1, 1, 1, 4, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_release", int'(in_ready), 1);
      tick();
      chk_out("bp_b2b", 1, 0, 0, 4, 0);
      in_valid = 1'b0;
      tick();
      chk_out("drain", 0, 0, 0, 4, 0);

      // key_load in the same cycle as an accept: compared with the old key, counters cleared.
      in_valid = 1'b1;
      in_data  = 5'd7;
      key_load = 1'b1;
      key_in   = 5'd31;
      tick();
      key_load = 1'b0;
      chk_out("kl_same", 1, 1, 0, 0, 0);
      in_data = 5'd31;
      tick();
      chk_out("newkey", 1, 1, 1, 1, 0);

      // Twenty more matches saturate both counters.
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("sat.run_count",   int'(run_count),   (i + 1 > 15) ? 15 : i + 1);
         chk("sat.match_total", int'(match_total), (i + 1 > 15) ? 15 : i + 1);
         chk("sat.locked",      int'(locked),      (i + 1 >= 3) ? 1 : 0);
      end

      // Reset mid-stream discards everything.
      rst_n = 1'b0;
      tick();
      chk_out("midreset", 0, 0, 0, 0, 0);
      chk("midreset.in_ready", int'(in_ready), 0);
      rst_n = 1'b1;
      tick();
      chk("after_reset.in_ready", int'(in_ready), 0);
      chk_out("after_reset", 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
